// File: rtl/ppu_types_pkg.sv
// Shared PPU types and dot/line timing for the mode sequencer and its STAT logic.
// One clk is one dot; all counts below are in dots or lines.
package ppu_types_pkg;

    localparam int DOTS_PER_LINE = 456;
    localparam int OAM_DOTS      = 80;
    localparam int VISIBLE_LINES = 144;
    localparam int TOTAL_LINES   = 154;
    localparam int MODE3_MAX     = 289;

    // Sized copies of the timing points so compares stay width-exact.
    localparam logic [8:0] DOT_LAST      = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_DRAW      = 9'(OAM_DOTS);
    localparam logic [7:0] LY_VBLANK     = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_LAST       = 8'(TOTAL_LINES - 1);
    localparam logic [8:0] MODE3_TC_LOAD = 9'(MODE3_MAX - 1);

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        DRAWING  = 2'd3
    } ppu_mode_t;

    function automatic logic stat_line(input ppu_mode_t  m,
                                       input logic       lyc_m,
                                       input logic [3:0] en);
        return ((m == HBLANK)   && en[0]) ||
               ((m == VBLANK)   && en[1]) ||
               ((m == OAM_SCAN) && en[2]) ||
               (lyc_m           && en[3]);
    endfunction

endpackage

// File: rtl/ppu_stat_irq.sv
// STAT interrupt line: registers the OR of the enabled sources and pulses on its rising edge.
// Fed with next-cycle mode/LYC values so the pulse lines up with the mode change it reports.
module ppu_stat_irq
    import ppu_types_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en_i,
    input  ppu_mode_t  mode_i,
    input  logic       lyc_match_i,
    input  logic [3:0] stat_en_i,
    output logic       stat_irq_o
);

    logic line_d;
    logic line_q;
    logic irq_d;
    logic irq_q;

    always_comb begin
        line_d = lcd_en_i & stat_line(mode_i, lyc_match_i, stat_en_i);
        irq_d  = line_d & ~line_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            line_q <= line_d;
            irq_q  <= irq_d;
        end
    end

    assign stat_irq_o = irq_q;

endmodule

// File: rtl/ppu_mode_sequencer.sv
// Dot-level PPU timing: walks OAM scan / drawing / HBlank per visible line, then VBlank lines,
// and publishes LY, mode, LYC compare, framebuffer enable/flush and the interrupt pulses.
//
// mode     | meaning
// HBLANK   | line finished drawing, or LCD off / reset
// VBLANK   | lines 144..153
// OAM_SCAN | dots 0..79 of a visible line
// DRAWING  | dot 80 until line_done or the mode-3 timer expires
module ppu_mode_sequencer
    import ppu_types_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       line_done,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_en,
    output ppu_mode_t  mode,
    output logic [7:0] ly,
    output logic [8:0] dot_cnt,
    output logic       dot_en,
    output logic       fb_flush,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       mode3_overrun
);

    ppu_mode_t  mode_d,      mode_q;
    logic       run_d,       run_q;
    logic [7:0] ly_d,        ly_q;
    logic [8:0] dot_d,       dot_q;
    logic [8:0] tmr_d,       tmr_q;
    logic       dot_en_d,    dot_en_q;
    logic       flush_d,     flush_q;
    logic       lyc_match_d, lyc_match_q;
    logic       vblank_d,    vblank_q;
    logic       overrun_d,   overrun_q;

    always_comb begin
        run_d       = lcd_en;
        ly_d        = '0;
        dot_d       = '0;
        mode_d      = HBLANK;
        tmr_d       = tmr_q;
        lyc_match_d = 1'b0;
        flush_d     = 1'b1;
        vblank_d    = 1'b0;
        overrun_d   = 1'b0;

        if (lcd_en) begin
            lyc_match_d = (ly_q == lyc);

            // The first enabled cycle after LCD-off/reset presents (0,0) rather than advancing.
            if (run_q) begin
                if (dot_q == DOT_LAST) begin
                    ly_d = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
                end else begin
                    ly_d  = ly_q;
                    dot_d = dot_q + 9'd1;
                end
            end

            if (ly_d >= LY_VBLANK) begin
                mode_d = VBLANK;
            end else if (dot_d < DOT_DRAW) begin
                mode_d = OAM_SCAN;
            end else if (dot_d == DOT_DRAW) begin
                mode_d = DRAWING;
                tmr_d  = MODE3_TC_LOAD;
            end else if (mode_q == DRAWING) begin
                // line_done wins over a coincident timer expiry.
                if (line_done) begin
                    mode_d = HBLANK;
                end else if (tmr_q == 9'd0) begin
                    mode_d    = HBLANK;
                    overrun_d = 1'b1;
                end else begin
                    mode_d = DRAWING;
                    tmr_d  = tmr_q - 9'd1;
                end
            end else begin
                mode_d = HBLANK;
            end

            flush_d  = (ly_d == 8'd0) && (dot_d == 9'd0);
            vblank_d = (ly_d == LY_VBLANK) && (dot_d == 9'd0);
        end
    end

    assign dot_en_d = (mode_d == DRAWING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            mode_q      <= HBLANK;
            ly_q        <= '0;
            dot_q       <= '0;
            tmr_q       <= '0;
            dot_en_q    <= 1'b0;
            flush_q     <= 1'b0;
            lyc_match_q <= 1'b0;
            vblank_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            run_q       <= run_d;
            mode_q      <= mode_d;
            ly_q        <= ly_d;
            dot_q       <= dot_d;
            tmr_q       <= tmr_d;
            dot_en_q    <= dot_en_d;
            flush_q     <= flush_d;
            lyc_match_q <= lyc_match_d;
            vblank_q    <= vblank_d;
            overrun_q   <= overrun_d;
        end
    end

    ppu_stat_irq u_stat (
        .clk         (clk),
        .reset       (reset),
        .lcd_en_i    (lcd_en),
        .mode_i      (mode_d),
        .lyc_match_i (lyc_match_d),
        .stat_en_i   (stat_en),
        .stat_irq_o  (stat_irq)
    );

    assign mode          = mode_q;
    assign ly            = ly_q;
    assign dot_cnt       = dot_q;
    assign dot_en        = dot_en_q;
    assign fb_flush      = flush_q;
    assign lyc_match     = lyc_match_q;
    assign vblank_irq    = vblank_q;
    assign mode3_overrun = overrun_q;

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// Bench for ppu_mode_sequencer: per-line behavioural model compared every cycle,
// plus literal counts/positions for the frame-level scenarios.
module tb_ppu_mode_sequencer;

    localparam int L_DOTS      = 456;
    localparam int L_OAM       = 80;
    localparam int L_VIS       = 144;
    localparam int L_TOTAL     = 154;
    localparam int L_DRAW_LAST = 80 + 289 - 1;
    localparam int M_HB = 0, M_VB = 1, M_OAM = 2, M_DR = 3;

    logic       clk = 1'b0;
    logic       reset, lcd_en, line_done;
    logic [7:0] lyc;
    logic [3:0] stat_en;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot_cnt;
    logic       dot_en, fb_flush, lyc_match, vblank_irq, stat_irq, mode3_overrun;

    int checks = 0;
    int errors = 0;

    ppu_mode_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .lcd_en        (lcd_en),
        .line_done     (line_done),
        .lyc           (lyc),
        .stat_en       (stat_en),
        .mode          (mode),
        .ly            (ly),
        .dot_cnt       (dot_cnt),
        .dot_en        (dot_en),
        .fb_flush      (fb_flush),
        .lyc_match     (lyc_match),
        .vblank_irq    (vblank_irq),
        .stat_irq      (stat_irq),
        .mode3_overrun (mode3_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (ly=%0d dot=%0d t=%0t)",
                         name, act, exp, ly, dot_cnt, $time);
        end
    endtask

    // Model: position counters plus, per visible line, the last dot that is still DRAWING.
    int m_ly = 0, m_dot = 0, m_end = L_DRAW_LAST;
    bit m_run = 0, m_line = 0;
    int e_mode = M_HB;
    bit e_flush = 0, e_lyc = 0, e_vb = 0, e_stat = 0, e_ovr = 0;
    int o_ly, o_dot;
    bit was_run, st;

    always @(posedge clk or posedge reset) begin
        if (reset || !lcd_en) begin
            m_run = 0; m_ly = 0; m_dot = 0; m_end = L_DRAW_LAST; m_line = 0;
            e_mode = M_HB; e_flush = !reset; e_lyc = 0; e_vb = 0; e_stat = 0; e_ovr = 0;
        end else begin
            o_ly = m_ly; o_dot = m_dot; was_run = m_run;
            e_lyc = (o_ly == int'(lyc));
            e_ovr = 0;
            if (was_run && o_ly < L_VIS && o_dot >= L_OAM && o_dot <= m_end) begin
                if (line_done) m_end = o_dot;
                else if (o_dot == L_DRAW_LAST) e_ovr = 1;
            end
            if (!was_run) begin
                m_run = 1; m_ly = 0; m_dot = 0;
            end else if (m_dot == L_DOTS - 1) begin
                m_dot = 0;
                m_ly = (m_ly == L_TOTAL - 1) ? 0 : m_ly + 1;
            end else begin
                m_dot++;
            end
            if (m_dot == 0) m_end = L_DRAW_LAST;
            if (m_ly >= L_VIS)       e_mode = M_VB;
            else if (m_dot < L_OAM)  e_mode = M_OAM;
            else if (m_dot <= m_end) e_mode = M_DR;
            else                     e_mode = M_HB;
            e_flush = (m_ly == 0 && m_dot == 0);
            e_vb    = (m_ly == L_VIS && m_dot == 0);
            st = (e_mode == M_HB && stat_en[0]) || (e_mode == M_VB && stat_en[1]) ||
                 (e_mode == M_OAM && stat_en[2]) || (e_lyc && stat_en[3]);
            e_stat = st && !m_line;
            m_line = st;
        end
    end

    int c_dot_en, c_ovr, c_vb, c_stat, c_stat_vb, c_lyc;
    int vb_ly, vb_dot, fs_ly, fs_dot;

    task automatic clear_counts();
        c_dot_en = 0; c_ovr = 0; c_vb = 0; c_stat = 0; c_stat_vb = 0; c_lyc = 0;
        vb_ly = -1; vb_dot = -1; fs_ly = -1; fs_dot = -1;
    endtask

    always @(negedge clk) begin
        chk("mode",          32'(mode),          e_mode);
        chk("ly",            32'(ly),            m_ly);
        chk("dot_cnt",       32'(dot_cnt),       m_dot);
        chk("dot_en",        32'(dot_en),        32'(e_mode == M_DR));
        chk("fb_flush",      32'(fb_flush),      32'(e_flush));
        chk("lyc_match",     32'(lyc_match),     32'(e_lyc));
        chk("vblank_irq",    32'(vblank_irq),    32'(e_vb));
        chk("stat_irq",      32'(stat_irq),      32'(e_stat));
        chk("mode3_overrun", 32'(mode3_overrun), 32'(e_ovr));
        if (!reset) begin
            if (dot_en) c_dot_en++;
            if (mode3_overrun) c_ovr++;
            if (lyc_match) c_lyc++;
            if (vblank_irq) begin c_vb++; vb_ly = ly; vb_dot = dot_cnt; end
            if (stat_irq) begin
                c_stat++;
                if (fs_ly < 0) begin fs_ly = ly; fs_dot = dot_cnt; end
                if (ly == 8'd144 && dot_cnt == 9'd0) c_stat_vb++;
            end
        end
    end

    int ld_mode = 0;
    bit rand_cfg = 0;

    // Advance one dot; inputs change 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
        case (ld_mode)
            0:       line_done = 1'b0;
            1:       line_done = (m_ly < L_VIS && m_dot == 252);
            default: line_done = (m_ly != 50) && ($urandom_range(0, 63) == 0);
        endcase
        if (rand_cfg && m_dot == 0) begin
            stat_en = 4'($urandom);
            lyc     = 8'($urandom_range(0, 60));
        end
    endtask

    task automatic run_until(input int tly, input int tdot, input int budget);
        int n = 0;
        while (!(m_run && m_ly == tly && m_dot == tdot) && n <= budget) begin
            step();
            n++;
        end
        chk("reach_target_in_budget", 32'(n <= budget), 1);
    endtask

    initial begin
        reset = 1'b1; lcd_en = 1'b0; line_done = 1'b0; lyc = 8'd0; stat_en = 4'd0;
        clear_counts();
        #1;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_ly", 32'(ly), 0);
        chk("rst_flush", 32'(fb_flush), 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) step();
        chk("lcd_off_flush_held", 32'(fb_flush), 1);

        // Lines 0..11: LYC=10 source only, line_done at dot 252.
        lyc = 8'd10; stat_en = 4'b1000; ld_mode = 1;
        clear_counts();
        lcd_en = 1'b1;
        step();
        chk("en_first_ly", 32'(ly), 0);
        chk("en_first_dot", 32'(dot_cnt), 0);
        chk("en_first_mode", 32'(mode), M_OAM);
        chk("en_first_flush", 32'(fb_flush), 1);
        step();
        chk("en_second_flush", 32'(fb_flush), 0);
        run_until(12, 0, 6000);
        chk("dot_en_cycles_12_lines", 32'(c_dot_en), 12 * 173);
        chk("lyc_match_cycles", 32'(c_lyc), 456);
        chk("lyc_stat_irq_count", 32'(c_stat), 1);
        chk("lyc_stat_irq_ly", 32'(fs_ly), 10);
        chk("lyc_stat_irq_dot", 32'(fs_dot), 1);
        chk("no_overrun_with_line_done", 32'(c_ovr), 0);

        // Rest of the frame: no line_done, HBLANK+VBLANK STAT sources.
        stat_en = 4'b0011; ld_mode = 0;
        clear_counts();
        run_until(147, 100, 70000);
        chk("overrun_count", 32'(c_ovr), 132);
        chk("vblank_count", 32'(c_vb), 1);
        chk("vblank_ly", 32'(vb_ly), 144);
        chk("vblank_dot", 32'(vb_dot), 0);
        chk("hblank_stat_count", 32'(c_stat), 132);
        chk("no_stat_at_vblank_handover", 32'(c_stat_vb), 0);

        // Asynchronous reset in VBlank.
        #1 reset = 1'b1;
        #1;
        chk("async_rst_mode", 32'(mode), 0);
        chk("async_rst_ly", 32'(ly), 0);
        chk("async_rst_dot", 32'(dot_cnt), 0);
        chk("async_rst_flush", 32'(fb_flush), 0);
        chk("async_rst_lyc", 32'(lyc_match), 0);
        step();
        step();
        reset = 1'b0;
        clear_counts();
        step();
        chk("rst_release_ly", 32'(ly), 0);
        chk("rst_release_dot", 32'(dot_cnt), 0);
        chk("rst_release_mode", 32'(mode), M_OAM);
        chk("rst_release_flush", 32'(fb_flush), 1);

        // Random traffic up to mid-DRAWING of line 50, then LCD off.
        ld_mode = 2; rand_cfg = 1;
        run_until(50, 200, 30000);
        chk("drawing_at_50_200", 32'(mode), M_DR);
        chk("no_vblank_before_144", 32'(c_vb), 0);
        lcd_en = 1'b0;
        step();
        chk("off_mode", 32'(mode), M_HB);
        chk("off_ly", 32'(ly), 0);
        chk("off_dot", 32'(dot_cnt), 0);
        chk("off_dot_en", 32'(dot_en), 0);
        chk("off_flush", 32'(fb_flush), 1);
        repeat (4) step();
        chk("off_flush_held", 32'(fb_flush), 1);
        lcd_en = 1'b1;
        step();
        chk("reen_mode", 32'(mode), M_OAM);
        chk("reen_flush", 32'(fb_flush), 1);
        step();
        chk("reen_flush_drop", 32'(fb_flush), 0);
        chk("reen_dot", 32'(dot_cnt), 1);

        for (int i = 0; i < 1500; i++) begin
            step();
            lcd_en = ($urandom_range(0, 599) != 0);
        end
        lcd_en = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
